axi4_lite_bus_arbiter: RTL and testbench

//  Two-requester arbiter sharing one AXI4-Lite master interface between the core's instruction-fetch port (I, read-only) and data port (D).

---
 rtl/axi4_lite_arb_pkg.sv | 36 +++
 rtl/arb_watchdog_counter.sv | 33 +++
 rtl/axi4_lite_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_axi4_lite_bus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_arb_pkg.sv
// Shared types and constants for the two-port AXI4-Lite bus arbiter.
// Covers the state encoding, grant identifiers and the captured request payload.
package axi4_lite_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

  localparam logic GRANT_I = 1'b1;
  localparam logic GRANT_D = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BUSY     = 3'd1,
    ST_RESP     = 3'd2,
    ST_ERR_RESP = 3'd3,
    ST_DRAIN    = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } arb_req_t;

  // Round-robin pick: a lone requester wins; on contention the port that did not win last time wins.
  function automatic logic rr_pick(input logic i_req, input logic d_req, input logic last_grant);
    if (i_req && d_req) begin
      return (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
    end
    return i_req ? GRANT_I : GRANT_D;
  endfunction

endpackage

// File: rtl/arb_watchdog_counter.sv
// Saturating BUSY-cycle counter for the arbiter watchdog.
// expired_c flags the last allowed cycle; TIMEOUT_CYCLES of 0 disables it.
module arb_watchdog_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins over count; the counter holds at its ceiling instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_c = WD_EN && (cnt_q == CNT_LAST);

endmodule

// File: rtl/axi4_lite_bus_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite native master port between the
// instruction-fetch and data ports, one transaction in flight, with a watchdog.
module axi4_lite_bus_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic              axi_clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_error,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_error,
  output logic              m_valid,
  output logic              m_instr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  arb_state_t state_q, state_d;
  logic       grant_q, grant_d;
  arb_req_t   hold_q, hold_d;

  logic              wd_clear_c;
  logic              wd_expired_c;
  logic              m_valid_d;
  logic              resp_d;
  logic              err_d;
  logic [DATA_W-1:0] rdata_d;
  logic              i_ready_d;
  logic              d_ready_d;

  arb_watchdog_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (axi_clk),
    .rst      (reset),
    .clear    (wd_clear_c),
    .enable   (state_q == ST_BUSY),
    .expired_c(wd_expired_c)
  );

  always_ff @(posedge axi_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_D;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
    end
  end

  // Next state, grant and request capture.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    hold_d     = hold_q;
    wd_clear_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid || d_valid) begin
          grant_d = rr_pick(i_valid, d_valid, grant_q);
          if (grant_d == GRANT_I) begin
            hold_d.addr  = i_addr;
            hold_d.wdata = '0;
            hold_d.wstrb = '0;
          end else begin
            hold_d.addr  = d_addr;
            hold_d.wdata = d_wdata;
            hold_d.wstrb = d_wstrb;
          end
          wd_clear_c = 1'b1;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (m_ready) begin
          state_d = ST_RESP;
        end else if (wd_expired_c) begin
          state_d = ST_ERR_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR_RESP: state_d = m_ready ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (m_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    m_valid_d = state_d inside {ST_BUSY, ST_ERR_RESP, ST_DRAIN};
    resp_d    = state_d inside {ST_RESP, ST_ERR_RESP};
    err_d     = (state_d == ST_ERR_RESP);
    rdata_d   = '0;
    if (err_d) begin
      rdata_d = ERR_DATA;
    end else if (state_d == ST_RESP) begin
      rdata_d = m_rdata;
    end
    i_ready_d = resp_d && (grant_d == GRANT_I);
    d_ready_d = resp_d && (grant_d == GRANT_D);
  end

  always_ff @(posedge axi_clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_instr <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
      i_ready <= 1'b0;
      i_rdata <= '0;
      i_error <= 1'b0;
      d_ready <= 1'b0;
      d_rdata <= '0;
      d_error <= 1'b0;
      busy    <= 1'b0;
    end else begin
      m_valid <= m_valid_d;
      m_instr <= m_valid_d && (grant_d == GRANT_I);
      m_addr  <= m_valid_d ? hold_d.addr : '0;
      m_wdata <= m_valid_d ? hold_d.wdata : '0;
      m_wstrb <= m_valid_d ? hold_d.wstrb : '0;
      i_ready <= i_ready_d;
      i_rdata <= i_ready_d ? rdata_d : '0;
      i_error <= i_ready_d && err_d;
      d_ready <= d_ready_d;
      d_rdata <= d_ready_d ? rdata_d : '0;
      d_error <= d_ready_d && err_d;
      busy    <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_axi4_lite_bus_arbiter.sv
// Self-checking bench for axi4_lite_bus_arbiter: directed scenarios then random
// traffic, checked against a transaction-level model of grant order and latency.
module tb_axi4_lite_bus_arbiter;

  localparam int          T       = 16;
  localparam logic [31:0] ERR_VAL = 32'hDEADBEEF;

  logic        axi_clk;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        i_error;
  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_error;
  logic        m_valid;
  logic        m_instr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        busy;

  int   total = 0;
  int   bad   = 0;
  bit   last_d;
  logic obs_instr;
  int   dly;
  bit   sn;

  axi4_lite_bus_arbiter #(
    .TIMEOUT_CYCLES(T),
    .ERR_DATA      (ERR_VAL)
  ) dut (
    .axi_clk(axi_clk),
    .reset  (reset),
    .i_valid(i_valid),
    .i_addr (i_addr),
    .i_ready(i_ready),
    .i_rdata(i_rdata),
    .i_error(i_error),
    .d_valid(d_valid),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_wstrb(d_wstrb),
    .d_ready(d_ready),
    .d_rdata(d_rdata),
    .d_error(d_error),
    .m_valid(m_valid),
    .m_instr(m_instr),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_wstrb(m_wstrb),
    .m_ready(m_ready),
    .m_rdata(m_rdata),
    .busy   (busy)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'h0);
    chk({tag, "_m_instr"}, 32'(m_instr), 32'h0);
    chk({tag, "_m_addr"},  m_addr,  32'h0);
    chk({tag, "_m_wdata"}, m_wdata, 32'h0);
    chk({tag, "_m_wstrb"}, 32'(m_wstrb), 32'h0);
    chk({tag, "_i_ready"}, 32'(i_ready), 32'h0);
    chk({tag, "_i_rdata"}, i_rdata, 32'h0);
    chk({tag, "_i_error"}, 32'(i_error), 32'h0);
    chk({tag, "_d_ready"}, 32'(d_ready), 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    chk({tag, "_d_error"}, 32'(d_error), 32'h0);
    chk({tag, "_busy"},    32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    i_valid = 1'b0;
    d_valid = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(negedge axi_clk);
    reset  = 1'b0;
    last_d = 1'b1;
  endtask

  // Model one transaction: grant from current valids, downstream answers after
  // 'delay' visible m_valid cycles; delays beyond T take the error path.
  // Returns at the first negedge where the arbiter is idle again.
  task automatic serve(input int delay, input logic [31:0] rd);
    logic        gi;
    logic [31:0] ea, ew;
    logic [3:0]  es;
    bit          seen, tmo, pulse;
    int          end_k;
    gi = (i_valid && d_valid) ? last_d : i_valid;
    ea = gi ? i_addr : d_addr;
    ew = gi ? 32'h0 : d_wdata;
    es = gi ? 4'h0 : d_wstrb;
    last_d = !gi;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge axi_clk);
      seen = (m_valid === 1'b1);
    end
    chk("m_valid_rise", 32'(seen), 32'h1);
    if (!seen) return;
    obs_instr = m_instr;
    tmo   = (delay > T);
    end_k = tmo ? delay + 1 : delay + 2;
    for (int k = 1; k <= end_k; k++) begin
      if (k > 1) @(negedge axi_clk);
      pulse = tmo ? (k == T + 1) : (k == delay + 1);
      chk("m_valid", 32'(m_valid), 32'(k <= delay));
      if (k <= delay) begin
        chk("m_instr", 32'(m_instr), 32'(gi));
        chk("m_addr",  m_addr, ea);
        chk("m_wdata", m_wdata, ew);
        chk("m_wstrb", 32'(m_wstrb), 32'(es));
      end
      chk("i_ready", 32'(i_ready), 32'(pulse && gi));
      chk("d_ready", 32'(d_ready), 32'(pulse && !gi));
      if (pulse) begin
        chk(gi ? "i_rdata" : "d_rdata", gi ? i_rdata : d_rdata, tmo ? ERR_VAL : rd);
        chk(gi ? "i_error" : "d_error", 32'(gi ? i_error : d_error), 32'(tmo));
        if (gi) i_valid = 1'b0;
        else    d_valid = 1'b0;
      end
      chk("busy", 32'(busy), 32'(k < end_k));
      m_ready = (k == delay);
      m_rdata = (k == delay) ? rd : $urandom();
    end
  endtask

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_addr  = '0;
    d_valid = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_wstrb = '0;
    m_ready = 1'b0;
    m_rdata = '0;
    last_d  = 1'b1;

    // Reset held three cycles, then idle.
    repeat (3) @(negedge axi_clk);
    chk_all_zero("rst_held");
    reset = 1'b0;
    repeat (2) @(negedge axi_clk);
    chk_all_zero("rst_idle");

    // Instruction fetch.
    i_valid = 1'b1;
    i_addr  = 32'h0000_0100;
    serve(3, 32'h0000_0013);
    chk("fetch_instr", 32'(obs_instr), 32'h1);

    // Data write then data read.
    d_valid = 1'b1;
    d_addr  = 32'h1234_5678;
    d_wdata = 32'hABCD_EF01;
    d_wstrb = 4'b1111;
    serve(2, $urandom());
    d_valid = 1'b1;
    d_addr  = 32'h8765_4321;
    d_wdata = $urandom();
    d_wstrb = 4'b0000;
    serve(1, 32'hCAFE_F00D);

    // Continuous contention alternates I, D, I, D.
    do_reset();
    i_valid = 1'b1;
    i_addr  = $urandom();
    d_valid = 1'b1;
    d_addr  = $urandom();
    d_wdata = $urandom();
    d_wstrb = 4'($urandom());
    for (int n = 0; n < 4; n++) begin
      serve(int'($urandom_range(1, 4)), $urandom());
      chk("rr_order", 32'(obs_instr), 32'(n % 2 == 0));
      if (!i_valid) begin i_valid = 1'b1; i_addr = $urandom(); end
      if (!d_valid) begin d_valid = 1'b1; d_addr = $urandom(); d_wdata = $urandom(); end
    end
    serve(1, $urandom());
    serve(1, $urandom());

    // Watchdog: late m_ready at cycle 20, plus the exact-threshold neighbours.
    i_valid = 1'b1;
    i_addr  = 32'h0000_0200;
    serve(20, $urandom());
    @(negedge axi_clk);
    chk("tmo_no_second_pulse", 32'(i_ready), 32'h0);
    chk("tmo_idle_busy", 32'(busy), 32'h0);
    i_valid = 1'b1;
    i_addr  = 32'h0000_0204;
    serve(T, 32'h1111_2222);
    d_valid = 1'b1;
    d_addr  = 32'h0000_0300;
    d_wdata = 32'h5555_AAAA;
    d_wstrb = 4'b0011;
    serve(T + 1, $urandom());

    // Reset in the middle of a data write.
    d_valid = 1'b1;
    d_addr  = 32'h0000_0400;
    d_wdata = $urandom();
    d_wstrb = 4'b1111;
    sn = 1'b0;
    for (int n = 0; n < 40 && !sn; n++) begin
      @(negedge axi_clk);
      sn = (m_valid === 1'b1);
    end
    chk("mid_rst_started", 32'(sn), 32'h1);
    @(negedge axi_clk);
    reset   = 1'b1;
    d_valid = 1'b0;
    #1;
    chk("mid_rst_m_valid", 32'(m_valid), 32'h0);
    chk("mid_rst_d_ready", 32'(d_ready), 32'h0);
    chk("mid_rst_busy",    32'(busy), 32'h0);
    @(negedge axi_clk);
    reset  = 1'b0;
    last_d = 1'b1;
    i_valid = 1'b1;
    i_addr  = $urandom();
    d_valid = 1'b1;
    d_addr  = $urandom();
    d_wdata = $urandom();
    d_wstrb = 4'($urandom());
    serve(2, $urandom());
    chk("post_rst_grant_i", 32'(obs_instr), 32'h1);
    serve(2, $urandom());
    chk("post_rst_grant_d", 32'(obs_instr), 32'h0);

    // Random traffic.
    for (int r = 0; r < 30; r++) begin
      if (!i_valid && ($urandom_range(0, 1) == 1)) begin
        i_valid = 1'b1;
        i_addr  = $urandom();
      end
      if (!d_valid && ($urandom_range(0, 1) == 1)) begin
        d_valid = 1'b1;
        d_addr  = $urandom();
        d_wdata = $urandom();
        d_wstrb = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom());
      end
      if (!i_valid && !d_valid) begin
        i_valid = 1'b1;
        i_addr  = $urandom();
      end
      dly = ($urandom_range(0, 4) == 0) ? int'($urandom_range(15, 19))
                                        : int'($urandom_range(1, 6));
      serve(dly, $urandom());
    end

    i_valid = 1'b0;
    d_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
